instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the F100-L soft processor. Drives the 10-bit address of the asynchronous program ROM and captures each returned 16-bit word. Assembles one- or two-word instructions (opcode word plus optional operand word) and hands them to the execute stage over a valid/ready handshake. Also handles control-flow redirects and the halt stop condition.

## Interface
Parameters:
- RESET_PC, 10'd0, program counter value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_address  output  10  program ROM address; equals pc in fetch states.
- mem_data  input  16  ROM word for mem_address, valid combinationally in the same cycle.
- redirect  input  1  one-cycle pulse; load pc from redirect_address (jump/call/return, or resume after halt).
- redirect_address  input  10  new fetch address.
- inst_valid  output  1  instruction registers hold a complete instruction.
- inst_ready  input  1  execute accepts the instruction this cycle.
- inst_word  output  16  opcode word.
- inst_operand  output  16  second word; 0 for one-word instructions.
- inst_two_word  output  1  1 when inst_operand is meaningful.
- inst_pc  output  10  address of inst_word.
- halted  output  1  a halt instruction was accepted; fetching stopped.

## Operation
- Length rule on captured word W:
  - W[15:12] != 0 and W[10:0] == 0 → two words (immediate/long operand; e.g. 16'h8000 lda #).
  - W[15:12] == 0 and W[9:8] == 2'b11 → two words (double-length shifts; e.g. 16'h0362).
  - Otherwise → one word (e.g. 16'h8001, 16'h4001, 16'h0003, 16'h0400).
- Halt: W == 16'h0400.
- States:
  - FETCH_OP: mem_address = pc. On the edge, latch inst_word = mem_data, inst_pc = pc, pc = pc+1. Go to FETCH_OPERAND if two-word, else VALID with inst_operand = 0 and inst_two_word = 0.
  - FETCH_OPERAND: mem_address = pc. On the edge, latch inst_operand = mem_data, inst_two_word = 1, pc = pc+1. Go to VALID.
  - VALID: inst_valid = 1; all inst_* outputs held stable while inst_ready = 0.
    - On inst_ready with a halt instruction: go to HALTED and set halted.
    - On inst_ready otherwise: go to FETCH_OP.
  - HALTED: no fetch; pc frozen; inst_valid = 0. Leave only via redirect.
- Redirect has highest priority in every state:
  - Next state is FETCH_OP, pc = redirect_address, halted = 0, inst_valid = 0 next cycle.
  - Any partially fetched instruction is discarded.
  - Redirect with inst_ready in VALID: the current instruction counts as accepted; the redirect still applies.
- pc arithmetic is 10-bit modulo: 1023+1 → 0. A two-word instruction at 1023 takes its operand from address 0.
- mem_address outside fetch states: pc (don't-care to the ROM, but deterministic).

## Timing
- Reset values: pc = RESET_PC, state FETCH_OP, inst_valid 0, inst_word 0, inst_operand 0, inst_two_word 0, inst_pc 0, halted 0, mem_address = RESET_PC.
- Reset mid-operation discards everything; the first fetch is at RESET_PC in the cycle after reset deasserts.
- One-word instruction: inst_valid rises 1 cycle after entering FETCH_OP.
- Two-word instruction: inst_valid rises 2 cycles after entering FETCH_OP.
- With inst_ready held high: one-word instruction every 2 cycles, two-word every 3.
- Redirect pulse in cycle N: mem_address = redirect_address in cycle N+1; inst_valid = 0 in cycle N+1.
- halted rises the cycle after the halt handshake and stays high until redirect or reset.

## Test plan
- ROM contents 8000,0019,4001,8000,0020,5001,0362,0001,8001,8000,fff0,0003,0400 with inst_ready=1 → issued in order:
  - (8000,0019,pc0), (4001,pc2), (8000,0020,pc3), (5001,pc5), (0362,0001,pc6), (8001,pc8), (8000,fff0,pc9), (0003,pc11), (0400,pc12).
  - Then halted = 1 and no further inst_valid.
- Backpressure: hold inst_ready=0 for 5 cycles at pc0 → inst_word 8000 / inst_operand 0019 stable, pc stays 2, no extra fetch.
- Redirect to 9 while in FETCH_OPERAND of the instruction at pc3 → that instruction is never issued; next issued (8000,fff0,pc9).
- While halted, redirect to 2 → halted clears; (4001,pc2) is issued next.
- RESET_PC=1023, ROM[1023]=8000, ROM[0]=1234 → issued (8000,1234,pc1023); pc becomes 1.
- Assert reset during VALID → next cycle inst_valid=0, halted=0, mem_address=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bundle of the ROM port, redirect input and the execute-stage handshake
// seen by the F100-L instruction fetch stage.
interface instruction_fetch_if;
  logic [9:0]  mem_address;
  logic [15:0] mem_data;
  logic        redirect;
  logic [9:0]  redirect_address;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_word;
  logic [15:0] inst_operand;
  logic        inst_two_word;
  logic [9:0]  inst_pc;
  logic        halted;

  modport master (
    output mem_address, inst_valid, inst_word, inst_operand, inst_two_word,
           inst_pc, halted,
    input  mem_data, redirect, redirect_address, inst_ready
  );

  modport slave (
    input  mem_address, inst_valid, inst_word, inst_operand, inst_two_word,
           inst_pc, halted,
    output mem_data, redirect, redirect_address, inst_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// F100-L instruction fetch: reads one- or two-word instructions from an
// asynchronous ROM and offers them to execute; handles redirects and halt.
module instruction_fetch #(
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_if.master        bus,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    FETCH_OP      = 2'd0,
    FETCH_OPERAND = 2'd1,
    VALID         = 2'd2,
    HALTED        = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [9:0]  pc, pc_n;
  logic [15:0] inst_word, inst_word_n;
  logic [15:0] inst_operand, inst_operand_n;
  logic        inst_two_word, inst_two_word_n;
  logic [9:0]  inst_pc, inst_pc_n;
  logic        halted, halted_n;

  // Operand-carrying forms: long/immediate addressing, and double-length shifts.
  function automatic logic needs_operand(input logic [15:0] w);
    return ((w[15:12] != 4'd0) && (w[10:0] == 11'd0)) ||
           ((w[15:12] == 4'd0) && (w[9:8] == 2'b11));
  endfunction

  // Handshake: an instruction transfers on a cycle where inst_valid and
  // inst_ready are both high; while valid and not ready every inst_* output holds.
  always_comb begin
    state_n         = state;
    pc_n            = pc;
    inst_word_n     = inst_word;
    inst_operand_n  = inst_operand;
    inst_two_word_n = inst_two_word;
    inst_pc_n       = inst_pc;
    halted_n        = halted;

    if (bus.redirect) begin
      state_n  = FETCH_OP;
      pc_n     = bus.redirect_address;
      halted_n = 1'b0;
    end else begin
      unique case (state)
        FETCH_OP: begin
          inst_word_n = bus.mem_data;
          inst_pc_n   = pc;
          pc_n        = pc + 10'd1;
          if (needs_operand(bus.mem_data)) begin
            state_n = FETCH_OPERAND;
          end else begin
            inst_operand_n  = 16'd0;
            inst_two_word_n = 1'b0;
            state_n         = VALID;
          end
        end
        FETCH_OPERAND: begin
          inst_operand_n  = bus.mem_data;
          inst_two_word_n = 1'b1;
          pc_n            = pc + 10'd1;
          state_n         = VALID;
        end
        VALID: begin
          if (bus.inst_ready) begin
            if (inst_word == 16'h0400) begin
              state_n  = HALTED;
              halted_n = 1'b1;
            end else begin
              state_n = FETCH_OP;
            end
          end
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: state_n = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH_OP;
      pc            <= RESET_PC;
      inst_word     <= 16'd0;
      inst_operand  <= 16'd0;
      inst_two_word <= 1'b0;
      inst_pc       <= 10'd0;
      halted        <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      inst_word     <= inst_word_n;
      inst_operand  <= inst_operand_n;
      inst_two_word <= inst_two_word_n;
      inst_pc       <= inst_pc_n;
      halted        <= halted_n;
    end
  end

  assign bus.mem_address   = pc;
  assign bus.inst_valid    = (state == VALID);
  assign bus.inst_word     = inst_word;
  assign bus.inst_operand  = inst_operand;
  assign bus.inst_two_word = inst_two_word;
  assign bus.inst_pc       = inst_pc;
  assign bus.halted        = halted;
  assign dbg_state         = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a scoreboard queue of expected
// instructions is drained by a monitor at every accepted handshake.
module tb_instruction_fetch;

  logic clk;
  logic reset, reset2;
  logic [1:0] dbg_state, dbg_state2;

  logic [15:0] rom  [0:1023];
  logic [15:0] rom2 [0:1023];

  logic [42:0] exp_q[$];
  logic [42:0] exp2_q[$];

  int n_checks;
  int n_fail;

  instruction_fetch_if ifc ();
  instruction_fetch_if ifc2 ();

  instruction_fetch #(.RESET_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .bus(ifc), .dbg_state(dbg_state)
  );

  instruction_fetch #(.RESET_PC(10'd1023)) dut2 (
    .clk(clk), .reset(reset2), .bus(ifc2), .dbg_state(dbg_state2)
  );

  assign ifc.mem_data  = rom[ifc.mem_address];
  assign ifc2.mem_data = rom2[ifc2.mem_address];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [42:0] pack(input logic [15:0] w, input logic [15:0] op,
                                       input logic two, input logic [9:0] pc);
    return {w, op, two, pc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int which, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((which == 1 ? ifc.inst_valid : ifc2.inst_valid) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_drain(input int which, input string name);
    for (int i = 0; i < 200; i++) begin
      if ((which == 1 ? exp_q.size() : exp2_q.size()) == 0) break;
      tick();
    end
    check(name, (which == 1 ? exp_q.size() : exp2_q.size()), 0);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset && ifc.inst_valid && ifc.inst_ready) begin
      logic [42:0] act, exp;
      act = pack(ifc.inst_word, ifc.inst_operand, ifc.inst_two_word, ifc.inst_pc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue: unexpected instruction %h", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL issue: got word/op/two/pc %h expected %h", act, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset2 && ifc2.inst_valid && ifc2.inst_ready) begin
      logic [42:0] act, exp;
      act = pack(ifc2.inst_word, ifc2.inst_operand, ifc2.inst_two_word, ifc2.inst_pc);
      n_checks++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_wrap: unexpected instruction %h", act);
      end else begin
        exp = exp2_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL issue_wrap: got word/op/two/pc %h expected %h", act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] prog [0:12];
    logic found;
    n_checks = 0;
    n_fail   = 0;
    prog = '{16'h8000, 16'h0019, 16'h4001, 16'h8000, 16'h0020, 16'h5001, 16'h0362,
             16'h0001, 16'h8001, 16'h8000, 16'hfff0, 16'h0003, 16'h0400};
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = 16'h0000;
      rom2[i] = 16'h0000;
    end
    for (int i = 0; i < 13; i++) rom[i] = prog[i];
    rom2[1023] = 16'h8000;
    rom2[0]    = 16'h1234;
    rom2[1]    = 16'h0400;

    reset = 1'b1;
    reset2 = 1'b1;
    ifc.inst_ready = 1'b0;
    ifc.redirect = 1'b0;
    ifc.redirect_address = 10'd0;
    ifc2.inst_ready = 1'b0;
    ifc2.redirect = 1'b0;
    ifc2.redirect_address = 10'd0;

    tick();
    tick();
    check("rst_valid", ifc.inst_valid, 1'b0);
    check("rst_halted", ifc.halted, 1'b0);
    check("rst_addr", ifc.mem_address, 10'd0);
    check("rst_word", ifc.inst_word, 16'd0);
    check("rst_operand", ifc.inst_operand, 16'd0);
    check("rst_two_word", ifc.inst_two_word, 1'b0);
    check("rst_pc", ifc.inst_pc, 10'd0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_addr_wrap", ifc2.mem_address, 10'd1023);

    // Backpressure on the first (two-word) instruction
    reset = 1'b0;
    reset2 = 1'b0;
    wait_valid(1, "bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_word", ifc.inst_word, 16'h8000);
      check("bp_operand", ifc.inst_operand, 16'h0019);
      check("bp_addr", ifc.mem_address, 10'd2);
      tick();
    end

    // Full program with ready held high
    exp_q.push_back(pack(16'h8000, 16'h0019, 1'b1, 10'd0));
    exp_q.push_back(pack(16'h4001, 16'h0000, 1'b0, 10'd2));
    exp_q.push_back(pack(16'h8000, 16'h0020, 1'b1, 10'd3));
    exp_q.push_back(pack(16'h5001, 16'h0000, 1'b0, 10'd5));
    exp_q.push_back(pack(16'h0362, 16'h0001, 1'b1, 10'd6));
    exp_q.push_back(pack(16'h8001, 16'h0000, 1'b0, 10'd8));
    exp_q.push_back(pack(16'h8000, 16'hfff0, 1'b1, 10'd9));
    exp_q.push_back(pack(16'h0003, 16'h0000, 1'b0, 10'd11));
    exp_q.push_back(pack(16'h0400, 16'h0000, 1'b0, 10'd12));
    ifc.inst_ready = 1'b1;
    wait_drain(1, "prog_drain");
    tick();
    check("halt_set", ifc.halted, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("halt_no_valid", ifc.inst_valid, 1'b0);
      check("halt_pc_frozen", ifc.mem_address, 10'd13);
      tick();
    end

    // Resume from halt via redirect to 2
    exp_q.push_back(pack(16'h4001, 16'h0000, 1'b0, 10'd2));
    ifc.redirect = 1'b1;
    ifc.redirect_address = 10'd2;
    tick();
    ifc.redirect = 1'b0;
    check("resume_halted", ifc.halted, 1'b0);
    check("resume_valid", ifc.inst_valid, 1'b0);
    check("resume_addr", ifc.mem_address, 10'd2);
    wait_drain(1, "resume_drain");

    // Redirect to 9 while fetching the operand of the instruction at pc3
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.mem_address == 10'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("operand_phase_seen", found, 1'b1);
    exp_q.push_back(pack(16'h8000, 16'hfff0, 1'b1, 10'd9));
    exp_q.push_back(pack(16'h0003, 16'h0000, 1'b0, 10'd11));
    exp_q.push_back(pack(16'h0400, 16'h0000, 1'b0, 10'd12));
    ifc.redirect = 1'b1;
    ifc.redirect_address = 10'd9;
    tick();
    ifc.redirect = 1'b0;
    check("redir_valid", ifc.inst_valid, 1'b0);
    check("redir_addr", ifc.mem_address, 10'd9);
    wait_drain(1, "redir_drain");
    tick();
    check("halt_again", ifc.halted, 1'b1);

    // Reset while an instruction is waiting in VALID
    ifc.inst_ready = 1'b0;
    ifc.redirect = 1'b1;
    ifc.redirect_address = 10'd2;
    tick();
    ifc.redirect = 1'b0;
    wait_valid(1, "pre_reset_valid");
    check("pre_reset_word", ifc.inst_word, 16'h4001);
    reset = 1'b1;
    tick();
    check("mid_reset_valid", ifc.inst_valid, 1'b0);
    check("mid_reset_halted", ifc.halted, 1'b0);
    check("mid_reset_addr", ifc.mem_address, 10'd0);
    reset = 1'b0;
    tick();
    check("post_reset_fetch", ifc.mem_address, 10'd1);

    // Wraparound instance: two-word instruction at 1023 takes operand from 0
    wait_valid(2, "wrap_valid");
    check("wrap_pc_after", ifc2.mem_address, 10'd1);
    exp2_q.push_back(pack(16'h8000, 16'h1234, 1'b1, 10'd1023));
    exp2_q.push_back(pack(16'h0400, 16'h0000, 1'b0, 10'd1));
    ifc2.inst_ready = 1'b1;
    wait_drain(2, "wrap_drain");
    tick();
    check("wrap_halted", ifc2.halted, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
